instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that produces the `instruction` / `PC_next` pair consumed by the IF/ID pipeline register. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel with an in-order response channel of arbitrary latency. Returned instructions are buffered in a 2-entry queue, so decode stalls never lose fetched words. Branch/jump redirects retarget the PC and discard all stale in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'hC800_0000, bubble word (opcode field 6'd50) driven when no instruction is available

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `fetch_stall`  in  1  1 = IF/ID register holding; do not pop the queue
- `redirect`  in  1  1 = load `redirect_pc`, flush queue and in-flight fetches
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 2'b00)
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  request address (current PC)
- `imem_rsp_valid`  in  1  response valid; exactly one per accepted request, in order, ≥1 cycle after acceptance
- `imem_rsp_data`  in  32  instruction word
- `instruction`  out  32  head-of-queue instruction, else `NOP_INSTR`
- `PC_next`  out  32  address of head instruction + 4, else 0
- `instr_valid`  out  1  head of queue valid

## Operation
- State: `pc` (32), queue of 2 entries {instr, pc+4}, `q_count` (0..2), `inflight` (0..2), `drop_count` (0..inflight).
- Pop: `pop = !fetch_stall && q_count != 0 && !redirect`.
- Request: `imem_req_valid = rst_n && !redirect && (q_count + inflight - pop) < 2`; `imem_req_addr = pc`. On accept (valid&ready): `pc <= pc + 4` (wraps mod 2^32), `inflight++`.
- Response: `inflight--`. If `drop_count != 0`: discard, `drop_count--`. Else push {`imem_rsp_data`, address+4} at tail.
- Push and pop in the same cycle: both apply; count unchanged; order preserved.
- Redirect (highest priority): `pc <= {redirect_pc[31:2],2'b00}`; queue emptied; no pop; no request issued that cycle; response arriving that cycle discarded; `drop_count <= inflight - imem_rsp_valid` (remaining in-flight words discarded on arrival).
- Overflow impossible by construction; a push into a full queue is a design error (assertion).
- Outputs are combinational from queue head registers (no memory-to-output combinational path unless bypass is compiled in).

## Timing
- Reset (`rst_n`=0 at edge): `pc`=`RESET_PC`, queue empty, `inflight`=`drop_count`=0. While held: `imem_req_valid`=0, `instruction`=`NOP_INSTR`, `PC_next`=0, `instr_valid`=0.
- Reset mid-operation: all state cleared at that edge; responses to pre-reset requests must not be issued by memory (memory is reset alongside).
- First request: first cycle with `rst_n`=1.
- Latency: request accepted at edge N, response in cycle N+L, output valid in cycle N+L+1.
- Throughput: 1 instruction/cycle sustained with L=1 and no stall.
- Redirect asserted in cycle R: outputs show bubble in R+1; request to target issued in R+1.

## Configuration
- `FETCH_BYPASS_EN` defined: when queue empty, `drop_count`=0, `!redirect`, and `imem_rsp_valid`=1, outputs show `imem_rsp_data` / address+4 / `instr_valid`=1 in the same cycle; if also `!fetch_stall` the word is consumed and not pushed. Output latency becomes N+L.
- Not defined: no bypass; latency N+L+1 as above.

## Test plan
- Reset release, L=1, ready=1, no stall -> addresses 0,4,8,… one per cycle; `PC_next` 4,8,12,… from cycle 3 with `instr_valid`=1 continuously.
- `fetch_stall`=1 for 5 cycles mid-stream -> outputs hold same word; `imem_req_valid` drops once `q_count`+`inflight`=2; no word lost or duplicated after release.
- `redirect`=1, `redirect_pc`=32'h0000_0103 with 2 in flight, L=3 -> next request addr 32'h100; both stale responses discarded; first valid `PC_next`=32'h104.
- `imem_req_ready` toggling 1/0, L=4 -> in-order delivery, `inflight` never >2, no overflow assertion.
- `RESET_PC`=32'hFFFF_FFF8, run 4 fetches -> addresses FFFF_FFF8, FFFF_FFFC, 0, 4; `PC_next` FFFF_FFFC, 0, 4, 8.
- `FETCH_BYPASS_EN` defined, empty queue, L=1 -> word at addr 0 visible in the response cycle (cycle 2 after reset release).

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch stage. Owns the PC and issues word-aligned
//               requests over a valid/ready channel to instruction memory.
//               Responses return in order with arbitrary latency and land in
//               a 2-entry queue feeding the IF/ID register. Redirects flush
//               the queue and discard every stale in-flight response.
//               Optional feature macro: FETCH_BYPASS_EN (response-to-output
//               bypass when the queue is empty).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hC800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction,
    output logic [31:0] PC_next,
    output logic        instr_valid
);

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    // Architectural state
    logic [31:0]      pc_q, pc_d;
    logic [1:0][31:0] instr_q, instr_d;
    logic [1:0][31:0] pcn_q, pcn_d;
    logic [1:0]       q_count_q, q_count_d;
    logic [1:0]       inflight_q, inflight_d;
    logic [1:0]       drop_q, drop_d;
    // Address of the next response that will be kept (responses are in
    // order and kept ones form a contiguous run from the last target).
    logic [31:0]      rsp_pc_q, rsp_pc_d;

    // Handshake / datapath control
    logic        w_pop;
    logic [2:0]  w_occupancy;
    logic        w_req_valid;
    logic        w_accept;
    logic        w_rsp_keep;
    logic        w_bypass_show;
    logic        w_bypass_take;
    logic        w_push;
    logic [31:0] w_redirect_tgt;
    logic [31:0] w_new_pcn;

    // Pop, request gating, and response classification
    always_comb begin
        w_redirect_tgt = redirect_pc & c_ALIGN_MASK;
        w_pop          = !fetch_stall && (q_count_q != 2'd0) && !redirect;
        w_occupancy    = {1'b0, q_count_q} + {1'b0, inflight_q} - {2'b00, w_pop};
        w_req_valid    = rst_n && !redirect && (w_occupancy < 3'd2);
        w_accept       = w_req_valid && imem_req_ready;
        w_rsp_keep     = imem_rsp_valid && !redirect && (drop_q == 2'd0);
        w_new_pcn      = rsp_pc_q + c_PC_STEP;
`ifdef FETCH_BYPASS_EN
        // Empty queue: a kept response goes straight to the outputs and is
        // consumed there if decode is not stalled.
        w_bypass_show  = w_rsp_keep && (q_count_q == 2'd0);
        w_bypass_take  = w_bypass_show && !fetch_stall;
`else
        w_bypass_show  = 1'b0;
        w_bypass_take  = 1'b0;
`endif
        w_push         = w_rsp_keep && !w_bypass_take;
    end

    // Next-state: PC, in-flight tracking, drop counter and queue shifting
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcn_d      = pcn_q;
        q_count_d  = q_count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        rsp_pc_d   = rsp_pc_q;

        if (redirect) begin
            // No request can be accepted this cycle, so only the arriving
            // response changes the in-flight count; the rest become drops.
            pc_d       = w_redirect_tgt;
            q_count_d  = 2'd0;
            inflight_d = inflight_q - {1'b0, imem_rsp_valid};
            drop_d     = inflight_q - {1'b0, imem_rsp_valid};
            rsp_pc_d   = w_redirect_tgt;
        end else begin
            if (w_accept) begin
                pc_d = pc_q + c_PC_STEP;
            end
            inflight_d = inflight_q + {1'b0, w_accept} - {1'b0, imem_rsp_valid};
            if (imem_rsp_valid && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            if (w_rsp_keep) begin
                rsp_pc_d = rsp_pc_q + c_PC_STEP;
            end

            case ({w_push, w_pop})
                2'b11: begin
                    // Count unchanged; the new word lands behind the survivor
                    if (q_count_q == 2'd1) begin
                        instr_d[0] = imem_rsp_data;
                        pcn_d[0]   = w_new_pcn;
                    end else begin
                        instr_d[0] = instr_q[1];
                        pcn_d[0]   = pcn_q[1];
                        instr_d[1] = imem_rsp_data;
                        pcn_d[1]   = w_new_pcn;
                    end
                end
                2'b01: begin
                    instr_d[0] = instr_q[1];
                    pcn_d[0]   = pcn_q[1];
                    q_count_d  = q_count_q - 2'd1;
                end
                2'b10: begin
                    if (q_count_q == 2'd0) begin
                        instr_d[0] = imem_rsp_data;
                        pcn_d[0]   = w_new_pcn;
                    end else begin
                        instr_d[1] = imem_rsp_data;
                        pcn_d[1]   = w_new_pcn;
                    end
                    q_count_d = q_count_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pcn_q      <= '0;
            q_count_q  <= 2'd0;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            rsp_pc_q   <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcn_q      <= pcn_d;
            q_count_q  <= q_count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rsp_pc_q   <= rsp_pc_d;
        end
    end

    // Output drive: queue head, else bypassed response, else bubble
    always_comb begin
        imem_req_valid = w_req_valid;
        imem_req_addr  = pc_q;
        if (q_count_q != 2'd0) begin
            instruction = instr_q[0];
            PC_next     = pcn_q[0];
            instr_valid = 1'b1;
        end else if (w_bypass_show) begin
            instruction = imem_rsp_data;
            PC_next     = w_new_pcn;
            instr_valid = 1'b1;
        end else begin
            instruction = NOP_INSTR;
            PC_next     = 32'h0000_0000;
            instr_valid = 1'b0;
        end
    end

    // Flow control guarantees the queue never overflows and at most two
    // requests are ever outstanding.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (q_count_q == 2'd2)));
    a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_q != 2'd3);
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_q <= inflight_q);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomized scoreboard bench for instr_fetch_unit. A memory
//               model returns in-order responses with variable latency; the
//               expected instruction stream is the sequential address run
//               starting at each reset/redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'hC800_0000;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID = 2;
`else
    localparam int FIRST_VALID = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic [31:0] PC_next;
    logic        instr_valid;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_stall    (fetch_stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .PC_next        (PC_next),
        .instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_fixed = 1;
    int          delivered = 0;
    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;
    logic [31:0] exp_req_addr;
    bit          prev_redirect = 1'b0;
    bit          prev_rst_low = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, expv, cyc);
        end
    endtask

    // Start a new expected stream at an aligned target
    task automatic restart_stream(input logic [31:0] tgt);
        exp_q.delete();
        exp_tail     = tgt & 32'hFFFF_FFFC;
        exp_req_addr = tgt & 32'hFFFF_FFFC;
    endtask

    // Memory model: in-order responses, one per cycle, cleared by reset
    always @(posedge clk) begin
        #2;
        cyc++;
        if (!rst_n) begin
            mq.delete();
            last_due       = 0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Monitor: compares outputs against the scoreboard every cycle
    always @(negedge clk) begin
        logic [31:0] e;
        int          lat;
        int          due;
        mreq_t       m;
        if (!rst_n) begin
            chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
            if (prev_rst_low) begin
                chk("valid_in_reset", {31'b0, instr_valid}, 32'd0);
                chk("instr_in_reset", instruction, NOP);
                chk("pcnext_in_reset", PC_next, 32'd0);
            end
        end else begin
            if (redirect)
                chk("req_valid_on_redirect", {31'b0, imem_req_valid}, 32'd0);
            if (prev_redirect)
                chk("bubble_after_redirect", {31'b0, instr_valid}, 32'd0);
            if (!instr_valid) begin
                chk("bubble_instr", instruction, NOP);
                chk("bubble_pcnext", PC_next, 32'd0);
            end else if (!redirect) begin
                while (exp_q.size() < 4) begin
                    exp_q.push_back(exp_tail);
                    exp_tail = exp_tail + 32'd4;
                end
                e = exp_q[0];
                chk("instruction", instruction, mem_word(e));
                chk("pc_next", PC_next, e + 32'd4);
                if (!fetch_stall) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req_addr);
                exp_req_addr = exp_req_addr + 32'd4;
                lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.addr = imem_req_addr;
                m.due  = due;
                mq.push_back(m);
                chk("outstanding_le_2", {31'b0, (mq.size() <= 2)}, 32'd1);
            end
        end
        prev_redirect = rst_n && redirect;
        prev_rst_low  = !rst_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        step();
        redirect    = 1'b1;
        redirect_pc = tgt;
        restart_stream(tgt);
        step();
        redirect    = 1'b0;
        redirect_pc = $urandom;
    endtask

    // Stimulus
    initial begin
        rst_n          = 1'b0;
        fetch_stall    = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        lat_fixed      = 1;
        repeat (3) step();

        // Reset release, L=1, no stall: stream from 0 at one word per cycle
        rst_n = 1'b1;
        restart_stream(32'h0);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            chk($sformatf("valid_cycle_%0d", j), {31'b0, instr_valid},
                (j >= FIRST_VALID) ? 32'd1 : 32'd0);
        end

        // Five-cycle decode stall: request channel must close, words hold
        step();
        fetch_stall = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j >= 3) chk("req_closed_in_stall", {31'b0, imem_req_valid}, 32'd0);
            step();
        end
        fetch_stall = 1'b0;
        repeat (6) step();

        // L=3 with requests in flight, redirect to an unaligned target
        lat_fixed = 3;
        repeat (10) step();
        do_redirect(32'h0000_0103);
        repeat (12) step();

        // Ready toggling, L=4
        lat_fixed = 4;
        for (int j = 0; j < 40; j++) begin
            imem_req_ready = ~imem_req_ready;
            step();
        end
        imem_req_ready = 1'b1;

        // Wrap-around through the top of the address space
        lat_fixed = 1;
        do_redirect(32'hFFFF_FFF8);
        repeat (10) step();

        // Randomized traffic: stalls, backpressure, latency, redirects, resets
        lat_fixed = 0;
        for (int j = 0; j < 3000; j++) begin
            fetch_stall    = ($urandom_range(0, 9) < 3);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) < 3) begin
                rst_n    = 1'b0;
                redirect = 1'b0;
                exp_q.delete();
                step();
                step();
                rst_n = 1'b1;
                restart_stream(32'h0);
            end else if ($urandom_range(0, 99) < 3) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 1) != 0) ? $urandom
                                                          : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
                restart_stream(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
            step();
        end
        redirect    = 1'b0;
        fetch_stall = 1'b0;
        repeat (10) step();

        chk("progress", {31'b0, (delivered > 300)}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
